uart_file_loader: RTL and testbench
===================================

Name: uart_file_loader

Overview:
- Hardware counterpart of the host-side file-transfer protocol used by the system UART console.
- On start, the block masters the iob_uart register port and sends the "send file" request byte (0x02). It then receives a 4-byte little-endian file size and the file payload.
- Payload bytes are packed LSB-first into 32-bit words and written sequentially to a memory write port (main RAM or DDR bridge).
- Sits between iob_uart (upstream, byte source) and the memory subsystem (downstream, word sink).

Parameters:
- MEM_ADDR_W, 24, word-address width of the memory write port.
- MAX_BYTES, 2**26, largest accepted file size in bytes.
- UART_DIV_VAL, 100, divider written to the UART DIV register (clock freq / baud).
- A_SOFT_RESET, 0, UART soft-reset register address.
- A_DIV, 1, UART divider register address.
- A_WRITE_WAIT, 2, UART tx-busy status register address.
- A_DATA, 3, UART data register address.
- A_RXEN, 4, UART rx-enable register address.
- A_READ_VALID, 5, UART rx-valid status register address.
- Integrators override A_* and UART_DIV_VAL from iob-uart.vh and system.vh.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse that begins a load; ignored while busy=1.
- busy, out, 1, high from the cycle after start until done.
- done, out, 1, single-cycle pulse at the end of a load (success or error).
- error, out, 1, sticky; set when size > MAX_BYTES; cleared by the next accepted start.
- byte_count, out, 32, number of payload bytes received so far.
- file_size, out, 32, size as received.
- uart_sel, out, 1, UART access select.
- uart_wr, out, 1, UART write strobe.
- uart_rd, out, 1, UART read strobe.
- uart_addr, out, 3, UART register address.
- uart_di, out, 32, UART write data.
- uart_do, in, 32, UART read data.
- uart_ready, in, 1, UART access complete.
- mem_valid, out, 1, memory write request.
- mem_addr, out, MEM_ADDR_W, word address.
- mem_wdata, out, 32, packed word.
- mem_wstrb, out, 4, byte enables.
- mem_ready, in, 1, memory write accepted.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; internal counters cleared. rst asserted mid-load aborts the load immediately, with no done pulse.
- UART access rule:
  - uart_sel, uart_addr, uart_rd/uart_wr and uart_di are held stable until the cycle in which uart_ready=1.
  - For reads, uart_do is sampled in that same cycle.
  - The strobes deassert the following cycle. Minimum 1 idle cycle between accesses.
- Memory rule:
  - mem_valid and its address/data/strobes are held until mem_ready=1; the transfer completes in that cycle.
  - mem_valid deasserts the next cycle unless another word is already queued. At most one word is outstanding.
- FSM states:
  - IDLE: on start, clear byte_count/error/word address and go to INIT.
  - INIT: four writes in order: SOFT_RESET=1, SOFT_RESET=0, DIV=UART_DIV_VAL, RXEN=1. Then REQ_WAIT.
  - REQ_WAIT: read WRITE_WAIT; repeat until bit0=0; then REQ_SEND.
  - REQ_SEND: write DATA=0x00000002. Then SIZE.
  - SIZE: per byte, poll READ_VALID until bit0=1, then read DATA and take bits [7:0]. Four bytes, first byte → file_size[7:0]. Then CHECK.
  - CHECK (1 cycle):
    - If size > MAX_BYTES: set error, go to DONE.
    - If size == 0: go to DONE.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: receive bytes with the same poll/read sequence. Byte k of a word goes to wdata[8k+7:8k] and sets wstrb[k]; byte_count increments per byte.
    - When 4 bytes are packed, or the last byte (byte_count == file_size) is packed, go to MEM_WR.
  - MEM_WR: issue the write at the current word address. On mem_ready, increment the address and clear the pack register and strobes. Return to PAYLOAD if bytes remain, else go to DONE.
  - DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- Final partial word: mem_wstrb reflects only the valid bytes (e.g. 1 byte → 4'b0001); the unused wdata bytes are 0.
- UART reads complete only via uart_ready; there is no timeout.
- The word address wraps modulo 2**MEM_ADDR_W.
- start in the same cycle as rst is ignored.

Test Plan:
- Reset, then start; the UART model answers 0x02 and sends size 8 plus bytes 11 22 33 44 55 66 77 88 → the INIT write sequence exactly as specified; two mem writes: addr 0 data 0x44332211 wstrb F, addr 1 data 0x88776655 wstrb F; done pulses once; byte_count=8; error=0.
- Size 5, bytes AA BB CC DD EE → the second write is addr 1, data 0x000000EE, wstrb 4'b0001.
- Size 0 → no mem_valid, done pulses, error=0.
- Size MAX_BYTES+1 → error=1, no payload reads, done pulses; a subsequent start clears error.
- mem_ready held low 10 cycles on the first write → mem_valid/addr/data stable throughout; no UART read is issued until acceptance; data is still correct.
- rst asserted mid-payload after 3 bytes → all outputs 0 next cycle, no done; a fresh start runs a complete load correctly.

Source files
------------

// File: rtl/uart_file_loader.sv
// UART file loader: drives the iob_uart register port to fetch a file
// (4-byte little-endian size, then payload) and writes it to memory as 32-bit words.
module uart_file_loader #(
    parameter int          MEM_ADDR_W   = 24,
    parameter logic [31:0] MAX_BYTES    = 32'h0400_0000,
    parameter int          UART_DIV_VAL = 100,
    parameter int          A_SOFT_RESET = 0,
    parameter int          A_DIV        = 1,
    parameter int          A_WRITE_WAIT = 2,
    parameter int          A_DATA       = 3,
    parameter int          A_RXEN       = 4,
    parameter int          A_READ_VALID = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           byte_count,
    output logic [31:0]           file_size,
    output logic                  uart_sel,
    output logic                  uart_wr,
    output logic                  uart_rd,
    output logic [2:0]            uart_addr,
    output logic [31:0]           uart_di,
    input  logic [31:0]           uart_do,
    input  logic                  uart_ready,
    output logic                  mem_valid,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_REQ_WAIT = 4'd2,
        S_REQ_SEND = 4'd3,
        S_SIZE     = 4'd4,
        S_CHECK    = 4'd5,
        S_PAYLOAD  = 4'd6,
        S_MEM_WR   = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t                state_r, state_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  error_r, error_s;
    logic [31:0]           byte_count_r, byte_count_s;
    logic [31:0]           file_size_r, file_size_s;
    logic                  uart_sel_r, uart_sel_s;
    logic                  uart_wr_r, uart_wr_s;
    logic                  uart_rd_r, uart_rd_s;
    logic [2:0]            uart_addr_r, uart_addr_s;
    logic [31:0]           uart_di_r, uart_di_s;
    logic                  mem_valid_r, mem_valid_s;
    logic [MEM_ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]           mem_wdata_r, mem_wdata_s;
    logic [3:0]            mem_wstrb_r, mem_wstrb_s;
    // step: INIT write index or SIZE byte index; rx_phase: 0 = poll READ_VALID, 1 = read DATA
    logic [1:0]            step_r, step_s;
    logic                  rx_phase_r, rx_phase_s;

    logic                  acc_idle_s;
    logic                  acc_done_s;
    logic                  issue_s;
    logic                  issue_wr_s;
    logic [2:0]            issue_addr_s;
    logic [31:0]           issue_di_s;
    logic [7:0]            rx_byte_s;
    logic                  unused_s;

    assign acc_done_s = uart_sel_r & uart_ready;
    assign acc_idle_s = ~uart_sel_r;
    assign rx_byte_s  = uart_do[7:0];
    assign unused_s   = ^uart_do[31:8];

    // Next-state, UART access and datapath updates; every register holds by default.
    always_comb begin
        state_s      = state_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        error_s      = error_r;
        byte_count_s = byte_count_r;
        file_size_s  = file_size_r;
        uart_sel_s   = uart_sel_r;
        uart_wr_s    = uart_wr_r;
        uart_rd_s    = uart_rd_r;
        uart_addr_s  = uart_addr_r;
        uart_di_s    = uart_di_r;
        mem_valid_s  = mem_valid_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_wstrb_s  = mem_wstrb_r;
        step_s       = step_r;
        rx_phase_s   = rx_phase_r;
        issue_s      = 1'b0;
        issue_wr_s   = 1'b0;
        issue_addr_s = 3'd0;
        issue_di_s   = 32'd0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_s       = 1'b1;
                    error_s      = 1'b0;
                    byte_count_s = 32'd0;
                    file_size_s  = 32'd0;
                    mem_addr_s   = '0;
                    mem_wdata_s  = 32'd0;
                    mem_wstrb_s  = 4'd0;
                    step_s       = 2'd0;
                    rx_phase_s   = 1'b0;
                    state_s      = S_INIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INIT: begin
                if (acc_idle_s) begin
                    issue_s    = 1'b1;
                    issue_wr_s = 1'b1;
                    case (step_r)
                        2'd0: begin issue_addr_s = 3'(A_SOFT_RESET); issue_di_s = 32'd1; end
                        2'd1: begin issue_addr_s = 3'(A_SOFT_RESET); issue_di_s = 32'd0; end
                        2'd2: begin issue_addr_s = 3'(A_DIV);        issue_di_s = 32'(UART_DIV_VAL); end
                        default: begin issue_addr_s = 3'(A_RXEN);    issue_di_s = 32'd1; end
                    endcase
                end else if (acc_done_s) begin
                    step_s = step_r + 2'd1;
                    if (step_r == 2'd3) begin
                        state_s = S_REQ_WAIT;
                    end else begin
                        state_s = S_INIT;
                    end
                end else begin
                    state_s = S_INIT;
                end
            end
            S_REQ_WAIT: begin
                if (acc_idle_s) begin
                    issue_s      = 1'b1;
                    issue_addr_s = 3'(A_WRITE_WAIT);
                end else if (acc_done_s && !uart_do[0]) begin
                    state_s = S_REQ_SEND;
                end else begin
                    state_s = S_REQ_WAIT;
                end
            end
            S_REQ_SEND: begin
                if (acc_idle_s) begin
                    issue_s      = 1'b1;
                    issue_wr_s   = 1'b1;
                    issue_addr_s = 3'(A_DATA);
                    issue_di_s   = 32'h0000_0002;
                end else if (acc_done_s) begin
                    step_s     = 2'd0;
                    rx_phase_s = 1'b0;
                    state_s    = S_SIZE;
                end else begin
                    state_s = S_REQ_SEND;
                end
            end
            S_SIZE: begin
                if (acc_idle_s) begin
                    issue_s      = 1'b1;
                    issue_addr_s = rx_phase_r ? 3'(A_DATA) : 3'(A_READ_VALID);
                end else if (acc_done_s) begin
                    if (!rx_phase_r) begin
                        rx_phase_s = uart_do[0];
                    end else begin
                        rx_phase_s = 1'b0;
                        file_size_s[{step_r, 3'b000} +: 8] = rx_byte_s;
                        step_s = step_r + 2'd1;
                        if (step_r == 2'd3) begin
                            state_s = S_CHECK;
                        end else begin
                            state_s = S_SIZE;
                        end
                    end
                end else begin
                    state_s = S_SIZE;
                end
            end
            S_CHECK: begin
                if (file_size_r > MAX_BYTES) begin
                    error_s = 1'b1;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_DONE;
                end else if (file_size_r == 32'd0) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_DONE;
                end else begin
                    state_s = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (acc_idle_s) begin
                    issue_s      = 1'b1;
                    issue_addr_s = rx_phase_r ? 3'(A_DATA) : 3'(A_READ_VALID);
                end else if (acc_done_s) begin
                    if (!rx_phase_r) begin
                        rx_phase_s = uart_do[0];
                    end else begin
                        rx_phase_s = 1'b0;
                        mem_wdata_s[{byte_count_r[1:0], 3'b000} +: 8] = rx_byte_s;
                        mem_wstrb_s[byte_count_r[1:0]] = 1'b1;
                        byte_count_s = byte_count_r + 32'd1;
                        // A word goes out when full or when it holds the file's last byte
                        if ((byte_count_r[1:0] == 2'd3) || ((byte_count_r + 32'd1) == file_size_r)) begin
                            mem_valid_s = 1'b1;
                            state_s     = S_MEM_WR;
                        end else begin
                            state_s = S_PAYLOAD;
                        end
                    end
                end else begin
                    state_s = S_PAYLOAD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    mem_valid_s = 1'b0;
                    mem_addr_s  = mem_addr_r + MEM_ADDR_W'(1);
                    mem_wdata_s = 32'd0;
                    mem_wstrb_s = 4'd0;
                    if (byte_count_r == file_size_r) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = S_DONE;
                    end else begin
                        state_s = S_PAYLOAD;
                    end
                end else begin
                    state_s = S_MEM_WR;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                busy_s      = 1'b0;
                mem_valid_s = 1'b0;
                state_s     = S_IDLE;
            end
        endcase

        // Strobes rise only from an idle port, which guarantees the gap cycle between accesses
        if (issue_s) begin
            uart_sel_s  = 1'b1;
            uart_wr_s   = issue_wr_s;
            uart_rd_s   = ~issue_wr_s;
            uart_addr_s = issue_addr_s;
            uart_di_s   = issue_di_s;
        end else if (acc_done_s) begin
            uart_sel_s = 1'b0;
            uart_wr_s  = 1'b0;
            uart_rd_s  = 1'b0;
        end else begin
            uart_sel_s = uart_sel_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            byte_count_r <= 32'd0;
            file_size_r  <= 32'd0;
            uart_sel_r   <= 1'b0;
            uart_wr_r    <= 1'b0;
            uart_rd_r    <= 1'b0;
            uart_addr_r  <= 3'd0;
            uart_di_r    <= 32'd0;
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            mem_wstrb_r  <= 4'd0;
            step_r       <= 2'd0;
            rx_phase_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
            byte_count_r <= byte_count_s;
            file_size_r  <= file_size_s;
            uart_sel_r   <= uart_sel_s;
            uart_wr_r    <= uart_wr_s;
            uart_rd_r    <= uart_rd_s;
            uart_addr_r  <= uart_addr_s;
            uart_di_r    <= uart_di_s;
            mem_valid_r  <= mem_valid_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_wstrb_r  <= mem_wstrb_s;
            step_r       <= step_s;
            rx_phase_r   <= rx_phase_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign byte_count = byte_count_r;
    assign file_size  = file_size_r;
    assign uart_sel   = uart_sel_r;
    assign uart_wr    = uart_wr_r;
    assign uart_rd    = uart_rd_r;
    assign uart_addr  = uart_addr_r;
    assign uart_di    = uart_di_r;
    assign mem_valid  = mem_valid_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;

endmodule

// File: tb/tb_uart_file_loader.sv
// Self-checking bench for uart_file_loader: UART and memory responder models plus
// a scoreboard of expected memory writes built from each file's bytes.
module tb_uart_file_loader;

    localparam int AW = 24;
    localparam logic [2:0] RA_WRITE_WAIT = 3'd2;
    localparam logic [2:0] RA_DATA       = 3'd3;
    localparam logic [2:0] RA_READ_VALID = 3'd5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } mem_exp_t;
    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst, start;
    logic          busy, done, error;
    logic [31:0]   byte_count, file_size;
    logic          uart_sel, uart_wr, uart_rd;
    logic [2:0]    uart_addr;
    logic [31:0]   uart_di, uart_do;
    logic          uart_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx_q[$];
    logic [34:0] wlog[$];
    logic [34:0] exp_wlog[5];
    mem_exp_t    exp_mem[$];
    int          done_cnt = 0;
    int          data_reads = 0;
    int          rd_during_mem = 0;
    int          stab_err = 0;
    int          tx_busy_polls = 0;
    int          mem_hold = 0;
    int          u_lat = 0;
    logic        mem_pend = 1'b0;
    logic [59:0] mem_saved;

    uart_file_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .error(error),
        .byte_count(byte_count), .file_size(file_size),
        .uart_sel(uart_sel), .uart_wr(uart_wr), .uart_rd(uart_rd),
        .uart_addr(uart_addr), .uart_di(uart_di), .uart_do(uart_do),
        .uart_ready(uart_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART and memory responders; outputs are sampled and inputs driven on the falling edge
    initial begin
        mem_exp_t e;
        logic have;
        uart_ready = 1'b0;
        uart_do    = 32'd0;
        mem_ready  = 1'b0;
        forever begin
            @(negedge clk);
            uart_ready = 1'b0;
            mem_ready  = 1'b0;
            if (done) done_cnt++;
            if (uart_sel && uart_rd && mem_valid) rd_during_mem++;
            if (uart_sel) begin
                if (u_lat > 0) begin
                    u_lat--;
                end else begin
                    uart_ready = 1'b1;
                    u_lat = $urandom_range(0, 2);
                    if (uart_wr) begin
                        wlog.push_back({uart_addr, uart_di});
                    end else if (uart_addr == RA_WRITE_WAIT) begin
                        uart_do = {31'h2AAA_5555, (tx_busy_polls > 0)};
                        if (tx_busy_polls > 0) tx_busy_polls--;
                    end else if (uart_addr == RA_READ_VALID) begin
                        uart_do = {31'h1234_5670, (rx_q.size() > 0) && ($urandom_range(0, 3) != 0)};
                    end else if (uart_addr == RA_DATA) begin
                        data_reads++;
                        uart_do = {24'hA5C3E1, (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00};
                    end else begin
                        uart_do = 32'd0;
                    end
                end
            end
            if (mem_valid) begin
                if (mem_pend) begin
                    if (mem_saved !== {mem_addr, mem_wdata, mem_wstrb}) stab_err++;
                end else begin
                    mem_saved = {mem_addr, mem_wdata, mem_wstrb};
                    mem_pend  = 1'b1;
                end
                if (mem_hold > 0) begin
                    mem_hold--;
                end else begin
                    mem_ready = 1'b1;
                    mem_pend  = 1'b0;
                    have = (exp_mem.size() != 0);
                    check_eq("mem_write_expected", have, 1);
                    if (have) begin
                        e = exp_mem.pop_front();
                        check_eq("mem_addr", mem_addr, e.addr);
                        check_eq("mem_wdata", mem_wdata, e.data);
                        check_eq("mem_wstrb", mem_wstrb, e.strb);
                    end
                end
            end
        end
    end

    task automatic push_file(input logic [31:0] size, input bq_t payload);
        logic [31:0] word;
        logic [3:0]  strb;
        for (int i = 0; i < 4; i++) rx_q.push_back(size[8*i +: 8]);
        word = 32'd0;
        strb = 4'd0;
        for (int i = 0; i < payload.size(); i++) begin
            rx_q.push_back(payload[i]);
            word[8*(i%4) +: 8] = payload[i];
            strb[i%4] = 1'b1;
            if ((i % 4 == 3) || (i == payload.size() - 1)) begin
                exp_mem.push_back('{addr: AW'(i / 4), data: word, strb: strb});
                word = 32'd0;
                strb = 4'd0;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string name, input logic [31:0] size, input bq_t payload,
                            input int hold, input logic exp_err);
        int d0;
        int cycles;
        wlog.delete();
        data_reads    = 0;
        rd_during_mem = 0;
        stab_err      = 0;
        tx_busy_polls = 2;
        mem_hold      = hold;
        push_file(size, payload);
        d0 = done_cnt;
        pulse_start();
        check_eq({name, "_busy_after_start"}, busy, 1);
        check_eq({name, "_error_cleared"}, error, 0);
        cycles = 0;
        while ((done_cnt == d0) && (cycles < 20000)) begin
            @(negedge clk);
            cycles++;
        end
        repeat (5) @(negedge clk);
        check_eq({name, "_done_pulses"}, done_cnt - d0, 1);
        check_eq({name, "_error"}, error, exp_err);
        check_eq({name, "_busy_end"}, busy, 0);
        check_eq({name, "_byte_count"}, byte_count, payload.size());
        check_eq({name, "_file_size"}, file_size, size);
        check_eq({name, "_data_reads"}, data_reads, 4 + payload.size());
        check_eq({name, "_mem_left"}, exp_mem.size(), 0);
        check_eq({name, "_rx_left"}, rx_q.size(), 0);
        check_eq({name, "_mem_stable"}, stab_err, 0);
        check_eq({name, "_rd_while_mem"}, rd_during_mem, 0);
        check_eq({name, "_uart_wr_count"}, wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq({name, "_uart_wr_seq"}, (i < wlog.size()) ? wlog[i] : 35'h7_FFFF_FFFF, exp_wlog[i]);
    endtask

    initial begin
        bq_t p;
        int  d0;
        int  cycles;
        exp_wlog[0] = {3'd0, 32'd1};
        exp_wlog[1] = {3'd0, 32'd0};
        exp_wlog[2] = {3'd1, 32'd100};
        exp_wlog[3] = {3'd4, 32'd1};
        exp_wlog[4] = {3'd3, 32'd2};
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("rst_ctrl", {busy, done, error, uart_sel, uart_wr, uart_rd, mem_valid}, 7'd0);
        check_eq("rst_counts", {byte_count, file_size}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("start_with_rst_ignored", {busy, uart_sel}, 2'd0);

        p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load("size8", 32'd8, p, 0, 1'b0);
        p = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load("size5", 32'd5, p, 0, 1'b0);
        p = {};
        run_load("size0", 32'd0, p, 0, 1'b0);
        run_load("oversize", 32'h0400_0001, p, 0, 1'b1);
        p = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("after_err", 32'd4, p, 0, 1'b0);
        p = {};
        for (int i = 0; i < 7; i++) p.push_back(8'($urandom));
        run_load("mem_hold", 32'd7, p, 10, 1'b0);

        // Abort mid-payload after three bytes
        tx_busy_polls = 0;
        p = {};
        for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
        push_file(32'd8, p);
        exp_mem.delete();
        d0 = done_cnt;
        pulse_start();
        cycles = 0;
        while ((byte_count != 32'd3) && (cycles < 5000)) begin
            @(negedge clk);
            cycles++;
        end
        check_eq("abort_reached_3", byte_count, 3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_ctrl", {busy, done, error, uart_sel, uart_wr, uart_rd, mem_valid}, 7'd0);
        check_eq("abort_counts", {byte_count, file_size}, 64'd0);
        check_eq("abort_bus", {uart_addr, uart_di, mem_wstrb}, 39'd0);
        check_eq("abort_mem", {mem_addr, mem_wdata}, 56'd0);
        rst = 1'b0;
        rx_q.delete();
        repeat (5) @(negedge clk);
        check_eq("abort_no_done", done_cnt - d0, 0);

        p = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF};
        run_load("after_abort", 32'd6, p, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
